// File: rtl/uart_rx_frame_ctrl.sv
// Frames UART receiver bytes into SYNC/TYPE/LEN/payload commands held for a valid/ack consumer.
// Define UART_FRAME_CHKSUM_EN to require and verify a trailing XOR checksum byte per frame.
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 17360,
    localparam int        AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          rx_en,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          frame_valid,
    input  logic          frame_ack,
    output logic [7:0]    frame_type,
    output logic [7:0]    frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_timeout,
    output logic [7:0]    drop_cnt
);
    localparam int            DEPTH     = 1 << AW;
    localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_TYPE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t        state;
    logic          rx_ready_q;
    logic          byte_ev;
    logic          is_sync;
    logic          to_run;
    logic          to_fire;
    logic          last_pay;
    logic [7:0]    type_q;
    logic [7:0]    len_q;
    logic [7:0]    idx;
    logic [TW-1:0] to_cnt;
    logic [7:0]    buffer [DEPTH];

    assign byte_ev  = rx_ready & ~rx_ready_q;
    assign is_sync  = (rx_data == SYNC_BYTE);
    assign to_run   = (state inside {S_TYPE, S_LEN, S_PAYLOAD, S_CHK});
    assign to_fire  = to_run & ~byte_ev & (to_cnt == TO_LAST);
    assign last_pay = (idx == len_q - 8'd1);
    assign rd_data  = buffer[rd_addr];

    // Payload storage is only written while collecting, so it stays frozen during HOLD.
    always_ff @(posedge clk) begin
        if (byte_ev && state == S_PAYLOAD) begin
            buffer[idx[AW-1:0]] <= rx_data;
        end
    end

`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0] chk;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk <= '0;
        end else if (byte_ev) begin
            if (state == S_HUNT || state == S_HOLD) begin
                chk <= '0;
            end else if (state != S_CHK) begin
                chk <= chk ^ rx_data;
            end
        end
    end
`else
    assign err_chk = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HUNT;
            rx_ready_q  <= 1'b0;
            rx_en       <= 1'b0;
            frame_valid <= 1'b0;
            frame_type  <= '0;
            frame_len   <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            drop_cnt    <= '0;
            to_cnt      <= '0;
            type_q      <= '0;
            len_q       <= '0;
            idx         <= '0;
`ifdef UART_FRAME_CHKSUM_EN
            err_chk     <= 1'b0;
`endif
        end else begin
            rx_ready_q  <= rx_ready;
            rx_en       <= ~to_fire;
            err_timeout <= to_fire;
            err_len     <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
            err_chk     <= 1'b0;
`endif
            to_cnt      <= (byte_ev || !to_run) ? '0 : to_cnt + 1'b1;

            // A byte arriving in the expiry cycle keeps to_fire low, so the byte wins.
            if (to_fire) begin
                state <= S_HUNT;
            end else if (byte_ev) begin
                case (state)
                    S_HUNT: begin
                        if (is_sync) state <= S_TYPE;
                    end
                    S_TYPE: begin
                        type_q <= rx_data;
                        state  <= S_LEN;
                    end
                    S_LEN: begin
                        len_q <= rx_data;
                        idx   <= '0;
                        if ({1'b0, rx_data} > MAX_LEN_W) begin
                            err_len <= 1'b1;
                            state   <= S_HUNT;
                        end else if (rx_data != 8'd0) begin
                            state <= S_PAYLOAD;
                        end else begin
`ifdef UART_FRAME_CHKSUM_EN
                            state <= S_CHK;
`else
                            frame_valid <= 1'b1;
                            frame_type  <= type_q;
                            frame_len   <= 8'd0;
                            state       <= S_HOLD;
`endif
                        end
                    end
                    S_PAYLOAD: begin
                        idx <= idx + 8'd1;
                        if (last_pay) begin
`ifdef UART_FRAME_CHKSUM_EN
                            state <= S_CHK;
`else
                            frame_valid <= 1'b1;
                            frame_type  <= type_q;
                            frame_len   <= len_q;
                            state       <= S_HOLD;
`endif
                        end
                    end
`ifdef UART_FRAME_CHKSUM_EN
                    S_CHK: begin
                        if (rx_data == chk) begin
                            frame_valid <= 1'b1;
                            frame_type  <= type_q;
                            frame_len   <= len_q;
                            state       <= S_HOLD;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= S_HUNT;
                        end
                    end
`endif
                    S_HOLD: begin
                        if (frame_ack) begin
                            frame_valid <= 1'b0;
                            state       <= is_sync ? S_TYPE : S_HUNT;
                        end else if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end else if (state == S_HOLD && frame_ack) begin
                frame_valid <= 1'b0;
                state       <= S_HUNT;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomized bench for uart_rx_frame_ctrl, checked against a queue-based frame parser model.
module tb_uart_rx_frame_ctrl;
    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 700;
    localparam int         AW      = $clog2(MAX_LEN);
`ifdef UART_FRAME_CHKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_en;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic          frame_valid;
    logic          frame_ack;
    logic [7:0]    frame_type;
    logic [7:0]    frame_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          err_chk;
    logic          err_len;
    logic          err_timeout;
    logic [7:0]    drop_cnt;

    uart_rx_frame_ctrl #(
        .MAX_LEN  (MAX_LEN),
        .SYNC_BYTE(SYNC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_en      (rx_en),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .frame_type (frame_type),
        .frame_len  (frame_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed pulse/low-cycle counts.
    int n_chk = 0, n_len = 0, n_to = 0, n_en_low = 0;
    bit armed = 1'b0;
    always @(negedge clk) begin
        if (err_chk)         n_chk++;
        if (err_len)         n_len++;
        if (err_timeout)     n_to++;
        if (armed && !rx_en) n_en_low++;
    end

    // Reference model state: bytes since SYNC, held frame, expected event counts.
    bit         in_frame = 1'b0;
    bit         holding  = 1'b0;
    logic [7:0] fr[$];
    logic [7:0] h_pay[$];
    logic [7:0] h_type, h_len;
    int         exp_chk = 0, exp_len = 0, exp_to = 0, exp_drop = 0;
    int         last_ev = 0;
    logic [7:0] tx[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_idle(input int t);
        if (in_frame && (t - last_ev) > TIMEOUT) begin
            exp_to++;
            in_frame = 1'b0;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int t, input bit ack);
        int need;
        logic [7:0] x;
        model_idle(t);
        if (holding) begin
            if (!ack) begin
                if (exp_drop < 255) exp_drop++;
                return;
            end
            holding = 1'b0;
        end
        if (!in_frame) begin
            if (b == SYNC) begin
                in_frame = 1'b1;
                fr.delete();
            end
            return;
        end
        fr.push_back(b);
        if (fr.size() < 2) return;
        if (fr[1] > MAX_LEN) begin
            exp_len++;
            in_frame = 1'b0;
            return;
        end
        need = 2 + int'(fr[1]) + (CHK_ON ? 1 : 0);
        if (fr.size() < need) return;
        in_frame = 1'b0;
        if (CHK_ON) begin
            x = 8'h00;
            for (int i = 0; i < need - 1; i++) x ^= fr[i];
            if (x != fr[need-1]) begin
                exp_chk++;
                return;
            end
        end
        holding = 1'b1;
        h_type  = fr[0];
        h_len   = fr[1];
        h_pay.delete();
        for (int i = 0; i < int'(fr[1]); i++) h_pay.push_back(fr[2+i]);
    endfunction

    // Raises rx_ready d cycles after the previous byte event and holds it h cycles.
    task automatic send_byte(input logic [7:0] b, input int d, input int h, input bit ack);
        int dd = (d < h + 1) ? h + 1 : d;
        while (cyc < last_ev + dd) begin
            @(posedge clk); #1;
        end
        rx_data   = b;
        rx_ready  = 1'b1;
        frame_ack = ack;
        model_byte(b, cyc, ack);
        last_ev = cyc;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        repeat (h - 1) begin
            @(posedge clk); #1;
        end
        rx_ready = 1'b0;
    endtask

    task automatic send_tx(input int d, input int h, input int start);
        for (int i = start; i < tx.size(); i++) send_byte(tx[i], d, h, 1'b0);
    endtask

    task automatic append_chk(input bit good);
        logic [7:0] x = 8'h00;
        if (CHK_ON) begin
            for (int i = 1; i < tx.size(); i++) x ^= tx[i];
            tx.push_back(good ? x : (x ^ 8'h01));
        end
    endtask

    task automatic check_state(input string tag);
        repeat (3) begin
            @(posedge clk); #1;
        end
        model_idle(cyc);
        check_eq({tag, "_valid"},    32'(frame_valid), 32'(holding));
        check_eq({tag, "_err_chk"},  n_chk,    exp_chk);
        check_eq({tag, "_err_len"},  n_len,    exp_len);
        check_eq({tag, "_err_to"},   n_to,     exp_to);
        check_eq({tag, "_rxen_low"}, n_en_low, exp_to);
        check_eq({tag, "_drops"},    32'(drop_cnt), exp_drop);
        if (holding) begin
            check_eq({tag, "_type"}, 32'(frame_type), 32'(h_type));
            check_eq({tag, "_len"},  32'(frame_len),  32'(h_len));
            for (int i = 0; i < h_pay.size(); i++) begin
                rd_addr = AW'(i);
                #1;
                check_eq($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(h_pay[i]));
            end
        end
    endtask

    task automatic ack_frame(input string tag);
        frame_ack = 1'b1;
        holding   = 1'b0;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        check_eq({tag, "_valid_after_ack"}, 32'(frame_valid), 32'(holding));
    endtask

    task automatic check_and_ack(input string tag);
        check_state(tag);
        if (holding) ack_frame(tag);
    endtask

    initial begin
        rst       = 1'b1;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        frame_ack = 1'b0;
        rd_addr   = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("rst_rx_en",    32'(rx_en),       0);
        check_eq("rst_valid",    32'(frame_valid), 0);
        check_eq("rst_type",     32'(frame_type),  0);
        check_eq("rst_len",      32'(frame_len),   0);
        check_eq("rst_drop",     32'(drop_cnt),    0);
        check_eq("rst_errs",     32'({err_chk, err_len, err_timeout}), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rx_en_after_rst", 32'(rx_en), 1);
        armed   = 1'b1;
        last_ev = cyc;

        // Good frame with readback and release.
        tx = '{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22};
        append_chk(1'b1);
        send_tx(3, 1, 0);
        check_state("frame_a");
        check_eq("a_type", 32'(frame_type), 32'h03);
        check_eq("a_len",  32'(frame_len),  32'h02);
        rd_addr = AW'(0); #1;
        check_eq("a_rd0", 32'(rd_data), 32'h11);
        rd_addr = AW'(1); #1;
        check_eq("a_rd1", 32'(rd_data), 32'h22);
        ack_frame("a");

        // Corrupted checksum, then a good frame.
        tx = '{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22};
        append_chk(1'b0);
        send_tx(3, 1, 0);
        check_and_ack("bad_chk");
        tx = '{8'hA5, 8'h05, 8'h01, 8'h7E};
        append_chk(1'b1);
        send_tx(4, 2, 0);
        check_and_ack("after_bad");

        // Oversize LEN, then a stray 00 in HUNT.
        tx = '{8'hA5, 8'h07, 8'h11, 8'h00};
        send_tx(3, 1, 0);
        check_state("len_err");

        // Stall after TYPE until the inter-byte timeout expires.
        tx = '{8'hA5, 8'h01};
        send_tx(3, 1, 0);
        repeat (TIMEOUT + 5) begin
            @(posedge clk); #1;
        end
        check_state("timeout");

        // Gaps of exactly TIMEOUT are tolerated; TIMEOUT+1 is not.
        tx = '{8'hA5, 8'h06, 8'h01, 8'h33};
        append_chk(1'b1);
        for (int i = 0; i < tx.size(); i++)
            send_byte(tx[i], (i == 1 || i == 2) ? TIMEOUT : 3, 1, 1'b0);
        check_and_ack("gap_eq_timeout");
        send_byte(8'hA5, 3, 1, 1'b0);
        send_byte(8'h06, 3, 1, 1'b0);
        send_byte(8'h01, 3, 1, 1'b0);
        send_byte(8'h33, TIMEOUT + 1, 1, 1'b0);
        check_state("gap_gt_timeout");

        // Zero-length frame.
        tx = '{8'hA5, 8'h09, 8'h00};
        append_chk(1'b1);
        send_tx(3, 1, 0);
        check_state("zero_len");
        check_eq("zero_len_len", 32'(frame_len), 0);
        ack_frame("zero_len");

        // Drops while holding, then ack coinciding with a SYNC byte.
        tx = '{8'hA5, 8'h04, 8'h01, 8'h55};
        append_chk(1'b1);
        send_tx(3, 1, 0);
        send_byte(8'h11, 3, 1, 1'b0);
        send_byte(8'h22, 3, 1, 1'b0);
        send_byte(8'h33, 3, 1, 1'b0);
        check_state("drops");
        check_eq("drop_cnt_3", 32'(drop_cnt), 3);
        send_byte(SYNC, 3, 1, 1'b1);
        check_state("ack_sync");
        check_eq("drop_cnt_kept", 32'(drop_cnt), 3);
        tx = '{8'hA5, 8'h04, 8'h01, 8'h66};
        append_chk(1'b1);
        send_tx(3, 1, 1);
        check_and_ack("after_ack_sync");

        // rx_ready held high for 500 cycles per byte.
        tx = '{8'hA5, 8'h0A, 8'h03, 8'h01, 8'h02, 8'h03};
        append_chk(1'b1);
        send_tx(502, 500, 0);
        check_and_ack("long_ready");

        // Randomized traffic.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] ln;
            int h;
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)), 3, 1, 1'b0);
            ln = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(MAX_LEN + 1, 255))
                                             : 8'($urandom_range(0, MAX_LEN));
            tx.delete();
            tx.push_back(SYNC);
            tx.push_back(8'($urandom_range(0, 255)));
            tx.push_back(ln);
            if (ln <= MAX_LEN) begin
                for (int i = 0; i < int'(ln); i++) tx.push_back(8'($urandom_range(0, 255)));
                append_chk($urandom_range(0, 4) != 0);
            end
            h = $urandom_range(1, 3);
            for (int i = 0; i < tx.size(); i++) send_byte(tx[i], h + $urandom_range(1, 6), h, 1'b0);
            check_state("rand");
            if (holding) begin
                repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 255)), 4, 1, 1'b0);
                if ($urandom_range(0, 3) == 0) begin
                    send_byte(SYNC, 4, 1, 1'b1);
                    check_state("rand_ack_sync");
                end else begin
                    ack_frame("rand");
                end
            end
        end
        repeat (TIMEOUT + 5) begin
            @(posedge clk); #1;
        end
        check_and_ack("flush");

        // Drop counter saturates at 255.
        tx = '{8'hA5, 8'h0B, 8'h01, 8'h77};
        append_chk(1'b1);
        send_tx(3, 1, 0);
        check_state("sat_hold");
        for (int i = 0; i < 260; i++) send_byte(8'h00, 2, 1, 1'b0);
        check_state("sat");
        check_eq("drop_sat", 32'(drop_cnt), 32'hFF);
        ack_frame("sat");

        // Reset in the middle of a frame.
        tx = '{8'hA5, 8'h02};
        send_tx(3, 1, 0);
        rst   = 1'b1;
        armed = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_eq("midrst_valid", 32'(frame_valid), 0);
        check_eq("midrst_drop",  32'(drop_cnt),    0);
        check_eq("midrst_rx_en", 32'(rx_en),       0);
        in_frame = 1'b0;
        holding  = 1'b0;
        exp_drop = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        armed   = 1'b1;
        last_ev = cyc;
        tx = '{8'hA5, 8'h0C, 8'h02, 8'h5A, 8'hC3};
        append_chk(1'b1);
        send_tx(3, 1, 0);
        check_and_ack("after_midrst");

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sits between the 115200 8N1 UART byte receiver and the PDU command decoder.
- Enables and resynchronises the receiver, then assembles received bytes into framed commands: SYNC, TYPE, LEN, payload, checksum.
- Validates each frame, buffers its payload and holds it for the consumer with a valid/ack handshake.
- Also handles inter-byte timeouts, length errors and drops while busy.

Parameters:
- MAX_LEN, 16: maximum payload bytes; sets buffer depth. Must be 1..255.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT, 17360: inter-byte timeout in clk cycles; about 2 byte times at 100 MHz.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rx_en  out  1  enable to UART receiver
- rx_ready  in  1  receiver byte-ready level; may stay high for many cycles
- rx_data  in  8  receiver byte
- frame_valid  out  1  complete good frame held
- frame_ack  in  1  consumer releases frame
- frame_type  out  8  TYPE byte of held frame
- frame_len  out  8  payload length of held frame
- rd_addr  in  $clog2(MAX_LEN)  payload read index
- rd_data  out  8  payload byte at rd_addr; combinational read
- err_chk  out  1  one-cycle pulse on checksum mismatch
- err_len  out  1  one-cycle pulse when LEN > MAX_LEN
- err_timeout  out  1  one-cycle pulse on inter-byte timeout
- drop_cnt  out  8  saturating count of bytes dropped while holding a frame

Behaviour:
- Reset values:
  - rx_en=0, frame_valid=0, frame_type=0, frame_len=0.
  - err_*=0, drop_cnt=0, state=HUNT, timeout counter=0, checksum=0, ready-edge register=0.
  - Buffer contents are not reset.
- rx_en: 1 from the first cycle after reset release. Forced 0 for exactly one cycle on timeout, which resets the receiver, then returns to 1.
- Byte event: `byte_ev = rx_ready & ~rx_ready_q`, where `rx_ready_q` is rx_ready registered. Exactly one event per received byte. rx_data is sampled in the event cycle. State and registers update at the next edge.
- Checksum: 8-bit XOR of TYPE, LEN and all payload bytes.
- State machine. Each transition below fires on a byte event unless stated otherwise:
  - HUNT:
    - byte == SYNC_BYTE -> TYPE; checksum cleared.
    - Any other byte is ignored.
  - TYPE: store type, checksum ^= byte -> LEN.
  - LEN:
    - LEN > MAX_LEN -> err_len pulse, go to HUNT.
    - LEN == 0 -> CHK.
    - Otherwise store LEN, clear byte index -> PAYLOAD.
    - checksum ^= byte in all cases.
  - PAYLOAD:
    - buffer[idx] = byte, checksum ^= byte, idx++.
    - When idx == LEN-1 -> CHK.
  - CHK:
    - byte == checksum -> HOLD; frame_valid=1 next cycle, frame_type and frame_len valid with it.
    - Mismatch -> err_chk pulse, go to HUNT.
  - HOLD:
    - frame_valid stays 1 and the buffer is frozen until frame_ack.
    - On frame_ack: frame_valid=0 next cycle -> HUNT.
    - A byte event without frame_ack increments drop_cnt, saturating at 255.
    - frame_ack and a byte event in the same cycle: the byte is processed as a HUNT byte, not dropped. If it is SYNC_BYTE, go directly to TYPE.
- Timeout:
  - The counter runs only in TYPE, LEN, PAYLOAD and CHK, and clears on every byte event and on state entry.
  - At TIMEOUT-1: err_timeout pulse, rx_en=0 for one cycle, go to HUNT. The partial frame is discarded.
  - A byte event in the same cycle as timeout expiry wins: no timeout.
- frame_ack outside HOLD is ignored.
- rd_addr >= frame_len returns stale buffer data; the consumer must not rely on it.
- rst mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro: UART_FRAME_CHKSUM_EN.
- Defined: checksum byte expected and verified; CHK state and err_chk behave as above.
- Undefined:
  - No checksum byte in the frame.
  - The last payload byte goes straight to HOLD; LEN == 0 goes directly from LEN to HOLD.
  - err_chk tied to 0 and the checksum logic is removed.

Test Plan:
- Frame A5 03 02 11 22 33 20 -> frame_valid=1, type=03, len=02; rd_addr 0/1 -> 11/22 (chk 03^02^11^22=32; see next line). Correction: use frame A5 03 02 11 22 32 -> frame_valid, type=03, len=02, rd 0->11, rd 1->22; ack -> frame_valid=0 next cycle.
- Same frame with checksum byte 33 -> err_chk single pulse, frame_valid stays 0. A following good frame is accepted.
- Frame A5 07 11 (MAX_LEN=16) -> err_len pulse, state HUNT. Next byte 00 is ignored.
- A5 01, then no byte for TIMEOUT cycles -> err_timeout pulse; rx_en low exactly one cycle.
- Zero-length frame A5 09 00 09 -> frame_valid, len=0.
- Hold a frame, send 3 bytes without ack -> drop_cnt=3. Assert frame_ack in the same cycle as a byte event of A5 -> state TYPE, drop_cnt unchanged.
- With rx_ready held high for 500 cycles per byte -> exactly one byte accepted per rising edge.
